// File: rtl/fetch_queue_pkg.sv
// Shared constants for the fetch queue and the decode stage that consumes it.
// NOP_INSTR is the bubble decode sees whenever the queue has nothing valid.
package fetch_queue_pkg;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam int          DEFAULT_W     = 32;
  localparam int          DEFAULT_DEPTH = 4;

endpackage : fetch_queue_pkg

// File: rtl/fetch_queue_reg.sv
// Generic enable register with asynchronous active-high reset.
// Pointer and occupancy state in the fetch queue are built from this primitive.
module fetch_queue_reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values of its neighbours, regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_o <= RESET_VAL;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule : fetch_queue_reg

// File: rtl/fetch_queue.sv
// Instruction fetch buffer: circular FIFO of {pc, instr} between fetch and decode,
// with PC back-pressure when full and a whole-queue squash on redirect.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter  int W     = DEFAULT_W,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [W-1:0]  in_pc,
  input  logic [W-1:0]  in_instr,
  output logic          in_ready,
  output logic          pc_write,
  input  logic          flush,
  output logic          out_valid,
  output logic [W-1:0]  out_pc,
  output logic [W-1:0]  out_instr,
  input  logic          out_ready,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          push, pop;

  logic [W-1:0]  pc_mem_q    [DEPTH];
  logic [W-1:0]  instr_mem_q [DEPTH];

  // Readiness comes only from registered occupancy, so decode's out_ready
  // never reaches the PC enable combinationally.
  assign in_ready  = (count_q < FULL_COUNT);
  assign pc_write  = in_ready;
  assign out_valid = (count_q != '0) && !flush;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready;

  // NOTE: every signal gets its default before any branch, so no path
  // through this block leaves a value unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  fetch_queue_reg #(.WIDTH(AW)) u_wr_ptr (
    .clk  (clk),
    .rst  (rst),
    .en_i (1'b1),
    .d_i  (wr_ptr_d),
    .q_o  (wr_ptr_q)
  );

  fetch_queue_reg #(.WIDTH(AW)) u_rd_ptr (
    .clk  (clk),
    .rst  (rst),
    .en_i (1'b1),
    .d_i  (rd_ptr_d),
    .q_o  (rd_ptr_q)
  );

  fetch_queue_reg #(.WIDTH(AW + 1)) u_count (
    .clk  (clk),
    .rst  (rst),
    .en_i (1'b1),
    .d_i  (count_d),
    .q_o  (count_q)
  );

  // NOTE: the storage array has no reset; stale entries are never visible
  // because out_valid and the output mux are governed by the reset counters.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= in_pc;
      instr_mem_q[wr_ptr_q] <= in_instr;
    end
  end

  assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : '0;
  assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : W'(NOP_INSTR);
  assign count     = count_q;

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_pc;
  logic [W-1:0]  in_instr;
  logic          in_ready;
  logic          pc_write;
  logic          flush;
  logic          out_valid;
  logic [W-1:0]  out_pc;
  logic [W-1:0]  out_instr;
  logic          out_ready;
  logic [AW:0]   count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        model_q[$];
  logic [31:0] popped[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;

  fetch_queue #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .pc_write  (pc_write),
    .flush     (flush),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return {pc[15:0] ^ 16'hA5C3, 16'h0033};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow directly from the abstract queue contents.
  task automatic check_outputs(input string ctx);
    logic        exp_valid;
    logic [31:0] exp_pc, exp_instr;
    exp_valid = (model_q.size() != 0) && !flush;
    exp_pc    = exp_valid ? model_q[0].pc    : 32'h0;
    exp_instr = exp_valid ? model_q[0].instr : NOP_INSTR;
    check({ctx, ".count"},     64'(count),     64'(model_q.size()));
    check({ctx, ".in_ready"},  64'(in_ready),  64'(model_q.size() < DEPTH));
    check({ctx, ".pc_write"},  64'(pc_write),  64'(model_q.size() < DEPTH));
    check({ctx, ".out_valid"}, 64'(out_valid), 64'(exp_valid));
    check({ctx, ".out_pc"},    64'(out_pc),    64'(exp_pc));
    check({ctx, ".out_instr"}, 64'(out_instr), 64'(exp_instr));
  endtask

  task automatic model_step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                            input logic ordy, input logic fl);
    int size_before;
    size_before = model_q.size();
    if (fl) begin
      model_q.delete();
    end else begin
      if (size_before != 0 && ordy) void'(model_q.pop_front());
      if (v && size_before < DEPTH) model_q.push_back('{pc: pc, instr: ins});
    end
  endtask

  // One clock cycle: drive at negedge, check before the rising edge, advance model.
  task automatic cycle(input string ctx, input logic v, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    @(negedge clk);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = mk_instr(pc);
    out_ready = ordy;
    flush     = fl;
    #1;
    check_outputs(ctx);
    if (out_valid && out_ready) popped.push_back(out_pc);
    @(posedge clk);
    model_step(v, pc, mk_instr(pc), ordy, fl);
  endtask

  task automatic drain(input string ctx);
    int budget;
    budget = 3 * DEPTH;
    while (model_q.size() != 0 && budget > 0) begin
      cycle(ctx, 1'b0, 32'h0, 1'b1, 1'b0);
      budget--;
    end
    check({ctx, ".drained"}, 64'(model_q.size()), 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs("reset");

    // Fill to full under decode stall; fifth push must bounce.
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 32'(i * 4), 1'b0, 1'b0);
    #1;
    check("fill.count_full", 64'(count), 64'd4);
    check("fill.pc_write_low", 64'(pc_write), 64'd0);
    cycle("fill.reject", 1'b1, 32'h10, 1'b0, 1'b0);
    #1;
    check("fill.head_kept", 64'(out_pc), 64'h0);

    // Pop in a full cycle frees a slot only for the following cycle.
    cycle("fullpop", 1'b1, 32'h10, 1'b1, 1'b0);
    #1;
    check("fullpop.count3", 64'(count), 64'd3);
    cycle("fullpop.push", 1'b1, 32'h10, 1'b0, 1'b0);
    #1;
    check("fullpop.count4", 64'(count), 64'd4);
    drain("fullpop.drain");

    // Stream ten PCs with decode always ready; pointers wrap twice.
    popped.delete();
    for (int i = 0; i < 10; i++) cycle("wrap", 1'b1, 32'(i * 4), 1'b1, 1'b0);
    drain("wrap.drain");
    check("wrap.n_popped", 64'(popped.size()), 64'd10);
    for (int i = 0; i < 10 && i < popped.size(); i++)
      check($sformatf("wrap.order%0d", i), 64'(popped[i]), 64'(i * 4));

    // Flush with a concurrent push: queue empties and the push is dropped.
    for (int i = 0; i < 3; i++) cycle("flush.fill", 1'b1, 32'(32'h20 + i * 4), 1'b0, 1'b0);
    cycle("flush.cycle", 1'b1, 32'h2C, 1'b1, 1'b1);
    #1;
    check("flush.count0", 64'(count), 64'd0);
    cycle("flush.repush", 1'b1, 32'h100, 1'b0, 1'b0);
    #1;
    check("flush.new_head", 64'(out_pc), 64'h100);

    // Decode stall: head stays stable, then releases one per cycle.
    cycle("stall.push", 1'b1, 32'h104, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle("stall.hold", 1'b0, 32'h0, 1'b0, 1'b0);
      check("stall.head_pc", 64'(out_pc), 64'h100);
      check("stall.head_instr", 64'(out_instr), 64'(mk_instr(32'h100)));
    end
    cycle("stall.rel1", 1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    check("stall.count1", 64'(count), 64'd1);
    cycle("stall.rel2", 1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    check("stall.count0", 64'(count), 64'd0);

    // Asynchronous reset mid-run with three entries and a pending push.
    for (int i = 0; i < 3; i++) cycle("rstmid.fill", 1'b1, 32'(32'h200 + i * 4), 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_pc    = 32'h300;
    in_instr = mk_instr(32'h300);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid.count", 64'(count), 64'd0);
    check("rstmid.out_valid", 64'(out_valid), 64'd0);
    check("rstmid.out_pc", 64'(out_pc), 64'h0);
    check("rstmid.out_instr", 64'(out_instr), 64'(NOP_INSTR));
    check("rstmid.in_ready", 64'(in_ready), 64'd1);
    check("rstmid.pc_write", 64'(pc_write), 64'd1);
    model_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check_outputs("rstmid.after");

    // Random traffic with occasional redirects.
    for (int i = 0; i < 400; i++) begin
      cycle("rand",
            1'($urandom_range(0, 3) != 0),
            $urandom,
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 19) == 0));
    end
    drain("rand.drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fetch_queue
